// File: rtl/jam_pkg.sv
// Shared types and sizes for the JAM cost-matrix responder.
// Table index is the 6-bit {W,J} concatenation.
package jam_pkg;
  localparam int N      = 8;
  localparam int COST_W = 8;
  localparam int RES_W  = 11;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } state_t;
endpackage

// File: rtl/cost_table.sv
// 64-entry cost register file.
// Synchronous write, registered read with a zero-force input.
module cost_table
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  input  logic              zero,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [2**IDX_W];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || zero) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/jam_cost_server.sv
// Cost-matrix responder for JAM: byte-serial load, indexed reads,
// result capture and a saturating read counter.
module jam_cost_server
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  input  logic              reload,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              jam_valid,
  input  logic [3:0]        MatchCount,
  input  logic [RES_W-1:0]  MinCost,
  output logic              table_ready,
  output logic              done,
  output logic [3:0]        result_count,
  output logic [RES_W-1:0]  result_cost,
  output logic [15:0]       access_count
);

  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic write_en;
  logic capture;
  logic serve;

  assign serve    = (state == SERVE);
  assign write_en = (state == LOAD) && load_valid && !reload;
  assign capture  = serve && jam_valid && !reload;

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (write_en && idx == 6'd63) state_nx = SERVE;
      SERVE:   if (jam_valid) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = LOAD;
    endcase
    // reload outranks every other event
    if (reload) state_nx = LOAD;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= LOAD;
      idx          <= '0;
      result_count <= '0;
      result_cost  <= '0;
      access_count <= '0;
    end else begin
      state <= state_nx;
      if (reload) begin
        idx          <= '0;
        result_count <= '0;
        result_cost  <= '0;
        access_count <= '0;
      end else begin
        if (write_en) idx <= idx + 6'd1;
        if (capture) begin
          result_count <= MatchCount;
          result_cost  <= MinCost;
        end
        if (serve && access_count != 16'hFFFF)
          access_count <= access_count + 16'd1;
      end
    end
  end

  cost_table u_table (
    .CLK   (CLK),
    .RST   (RST),
    .we    (write_en),
    .waddr (idx),
    .wdata (load_data),
    .raddr ({W, J}),
    .zero  (!serve || reload),
    .rdata (Cost)
  );

  assign load_ready  = (state == LOAD);
  assign table_ready = serve;
  assign done        = (state == DONE);

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: directed vectors,
// hand sequences and random traffic against a behavioural model.
module tb_jam_cost_server;

  logic        CLK = 0;
  logic        RST = 0;
  logic        load_valid = 0;
  logic [7:0]  load_data = 0;
  logic        load_ready;
  logic        reload = 0;
  logic [2:0]  W = 0;
  logic [2:0]  J = 0;
  logic [7:0]  Cost;
  logic        jam_valid = 0;
  logic [3:0]  MatchCount = 0;
  logic [10:0] MinCost = 0;
  logic        table_ready;
  logic        done;
  logic [3:0]  result_count;
  logic [10:0] result_cost;
  logic [15:0] access_count;

  jam_cost_server dut (
    .CLK(CLK), .RST(RST),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .reload(reload),
    .W(W), .J(J), .Cost(Cost),
    .jam_valid(jam_valid), .MatchCount(MatchCount),
    .MinCost(MinCost), .table_ready(table_ready),
    .done(done), .result_count(result_count),
    .result_cost(result_cost), .access_count(access_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // model: 0 = loading, 1 = serving, 2 = finished
  int        m_phase = 0;
  int        m_pos = 0;
  int        m_tab [64];
  int        m_cost = 0;
  int        m_rc = 0;
  int        m_rcost = 0;
  int        m_acc = 0;
  logic [7:0] nb [64];

  typedef struct {
    int w;
    int j;
    int exp;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!RST) begin
      m_phase = 0; m_pos = 0; m_cost = 0;
      m_rc = 0; m_rcost = 0; m_acc = 0;
      foreach (m_tab[i]) m_tab[i] = 0;
    end else if (reload) begin
      m_phase = 0; m_pos = 0; m_cost = 0;
      m_rc = 0; m_rcost = 0; m_acc = 0;
    end else if (m_phase == 0) begin
      m_cost = 0;
      if (load_valid) begin
        m_tab[m_pos] = load_data;
        if (m_pos == 63) begin
          m_pos = 0;
          m_phase = 1;
        end else begin
          m_pos++;
        end
      end
    end else if (m_phase == 1) begin
      m_cost = m_tab[W * 8 + J];
      if (m_acc < 65535) m_acc++;
      if (jam_valid) begin
        m_rc = MatchCount;
        m_rcost = MinCost;
        m_phase = 2;
      end
    end else begin
      m_cost = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk("cost", Cost, m_cost);
    chk("load_ready", load_ready, m_phase == 0);
    chk("table_ready", table_ready, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("result_count", result_count, m_rc);
    chk("result_cost", result_cost, m_rcost);
    chk("access_count", access_count, m_acc);
  endtask

  task automatic load_all(input bit gaps);
    for (int i = 0; i < 64; i++) begin
      if (gaps && (i == 10 || i == 40)) begin
        load_valid = 0;
        load_data = 8'hA5;
        tick();
      end
      load_valid = 1;
      load_data = nb[i];
      tick();
    end
    load_valid = 0;
  endtask

  initial begin
    vecs[0] = '{3, 5, 29};
    vecs[1] = '{7, 7, 63};
    vecs[2] = '{0, 0, 0};
    vecs[3] = '{0, 7, 7};
    vecs[4] = '{7, 0, 56};
    vecs[5] = '{5, 2, 42};

    // reset with random inputs
    for (int c = 0; c < 2; c++) begin
      RST = 0;
      load_valid = 1'($urandom);
      load_data = 8'($urandom);
      reload = 1'($urandom);
      W = 3'($urandom);
      J = 3'($urandom);
      jam_valid = 1'($urandom);
      MatchCount = 4'($urandom);
      MinCost = 11'($urandom);
      tick();
    end
    chk("rst_load_ready", load_ready, 1);
    chk("rst_cost", Cost, 0);
    chk("rst_table_ready", table_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_access", access_count, 0);
    RST = 1; reload = 0; load_valid = 0; jam_valid = 0;

    // identity table with gaps
    for (int i = 0; i < 64; i++) nb[i] = 8'(i);
    load_all(1);
    chk("ready_after_63", table_ready, 1);
    chk("load_ready_off", load_ready, 0);

    foreach (vecs[k]) begin
      W = 3'(vecs[k].w);
      J = 3'(vecs[k].j);
      tick();
      chk("vec_cost", Cost, vecs[k].exp);
    end

    // result capture on the 100th serve cycle
    for (int g = 0; g < 200 && m_acc < 99; g++) begin
      W = 3'($urandom); J = 3'($urandom);
      tick();
    end
    jam_valid = 1; MatchCount = 2; MinCost = 1234;
    tick();
    jam_valid = 0;
    chk("cap_done", done, 1);
    chk("cap_count", result_count, 2);
    chk("cap_cost", result_cost, 1234);
    chk("cap_access", access_count, 100);
    tick();
    chk("done_cost_zero", Cost, 0);
    tick();
    chk("done_access_frozen", access_count, 100);

    // reload vs jam_valid
    reload = 1; tick(); reload = 0;
    load_all(0);
    for (int c = 0; c < 5; c++) tick();
    reload = 1; jam_valid = 1; MatchCount = 9; MinCost = 777;
    tick();
    reload = 0; jam_valid = 0;
    chk("rl_load_ready", load_ready, 1);
    chk("rl_done", done, 0);
    chk("rl_result_cost", result_cost, 0);
    chk("rl_access", access_count, 0);
    for (int i = 0; i < 64; i++) nb[i] = 8'hFF;
    load_all(0);
    for (int c = 0; c < 4; c++) begin
      W = 3'($urandom); J = 3'($urandom);
      tick();
      chk("ff_cost", Cost, 255);
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom % 300) != 0;
      reload = ($urandom % 60) == 0;
      load_valid = ($urandom % 4) != 0;
      load_data = 8'($urandom);
      W = 3'($urandom); J = 3'($urandom);
      jam_valid = ($urandom % 50) == 0;
      MatchCount = 4'($urandom);
      MinCost = 11'($urandom);
      tick();
    end
    RST = 1; reload = 0; load_valid = 0; jam_valid = 0;

    // reset mid-load
    reload = 1; tick(); reload = 0;
    for (int i = 0; i < 64; i++) nb[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      load_valid = 1; load_data = 8'($urandom);
      tick();
    end
    load_valid = 0; RST = 0; tick(); RST = 1;
    load_all(0);
    W = 0; J = 0; tick();
    chk("midrst_entry0", Cost, nb[0]);
    W = 7; J = 7; tick();
    chk("midrst_entry63", Cost, nb[63]);

    // saturation
    for (int c = 0; c < 70000; c++) begin
      W = 3'($urandom); J = 3'($urandom);
      tick();
    end
    chk("sat_access", access_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
